// File: rtl/anneal_sequencer_if.sv
// Command broadcast bus from anneal_sequencer (master) to every node of the array (slave).
interface anneal_sequencer_if;
  logic [1:0] opt_command;
  logic       random_run;
  logic [2:0] distance_com;
  logic       metropolis_run;
  logic       replica_run;
  logic       exchange_run;
  logic       exchange_valid;
  logic       exchange_bank;
  logic       distance_shift;
  logic       exchange_shift_d;

  modport master (
    output opt_command, random_run, distance_com, metropolis_run, replica_run,
           exchange_run, exchange_valid, exchange_bank, distance_shift, exchange_shift_d
  );

  modport slave (
    input  opt_command, random_run, distance_com, metropolis_run, replica_run,
           exchange_run, exchange_valid, exchange_bank, distance_shift, exchange_shift_d
  );
endinterface

// File: rtl/anneal_sequencer.sv
// Annealing command sequencer: runs N iterations of the node command schedule, then an optional dump.
// Optional cycle_count perf counter is built only when SEQ_PERF_CNT_EN is defined.
module anneal_sequencer #(
  parameter int unsigned REPLICA_NUM = 32,
  parameter int unsigned CITY_NUM    = 64,
  parameter int unsigned DIST_CYC    = 4,
  parameter int unsigned EXCH_CYC    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] iter_num,
  input  logic [1:0]  opt_mode,
  input  logic        dump_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] iter_cnt,
  output logic [31:0] cycle_count,
  anneal_sequencer_if.master cmd
);

  localparam int unsigned MAX_PH   = (DIST_CYC > EXCH_CYC) ? DIST_CYC : EXCH_CYC;
  localparam int unsigned MAX_DUMP = (REPLICA_NUM > CITY_NUM) ? REPLICA_NUM : CITY_NUM;
  localparam int unsigned MAX_LEN  = (MAX_PH > MAX_DUMP) ? MAX_PH : MAX_DUMP;
  localparam int unsigned CNT_W    = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] DIST_LAST = CNT_W'(DIST_CYC - 1);
  localparam logic [CNT_W-1:0] EXCH_LAST = CNT_W'(EXCH_CYC - 1);
  localparam logic [CNT_W-1:0] REPL_LAST = CNT_W'(REPLICA_NUM - 1);
  localparam logic [CNT_W-1:0] CITY_LAST = CNT_W'(CITY_NUM - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_RAND  = 4'd1;
  localparam logic [3:0] S_DIST  = 4'd2;
  localparam logic [3:0] S_METRO = 4'd3;
  localparam logic [3:0] S_REPL  = 4'd4;
  localparam logic [3:0] S_EXCH  = 4'd5;
  localparam logic [3:0] S_EWAIT = 4'd6;
  localparam logic [3:0] S_DUMPD = 4'd7;
  localparam logic [3:0] S_DUMPO = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] phase, phase_nx;
  logic             stop_q, stop_nx;
  logic [31:0]      iter_num_q, iter_num_nx;
  logic [31:0]      iter_cnt_q, iter_cnt_nx;
  logic [1:0]       mode_q, mode_nx;
  logic [1:0]       opt_q, opt_nx;
  logic             dump_q, dump_nx;
  logic             bank_q, bank_nx;
  logic             run_st;

  logic       busy_nx, done_nx, rr_nx, metro_nx, repl_nx, exch_nx, ev_nx, dshift_nx, eshift_nx;
  logic [2:0] dcom_nx;

  assign iter_cnt          = iter_cnt_q;
  assign cmd.opt_command   = opt_q;
  assign cmd.exchange_bank = bank_q;

  // State, run context and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= S_IDLE;
      phase                <= '0;
      stop_q               <= 1'b0;
      iter_num_q           <= '0;
      iter_cnt_q           <= '0;
      mode_q               <= '0;
      opt_q                <= '0;
      dump_q               <= 1'b0;
      bank_q               <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      cmd.random_run       <= 1'b0;
      cmd.distance_com     <= '0;
      cmd.metropolis_run   <= 1'b0;
      cmd.replica_run      <= 1'b0;
      cmd.exchange_run     <= 1'b0;
      cmd.exchange_valid   <= 1'b0;
      cmd.distance_shift   <= 1'b0;
      cmd.exchange_shift_d <= 1'b0;
    end else begin
      state                <= state_nx;
      phase                <= phase_nx;
      stop_q               <= stop_nx;
      iter_num_q           <= iter_num_nx;
      iter_cnt_q           <= iter_cnt_nx;
      mode_q               <= mode_nx;
      opt_q                <= opt_nx;
      dump_q               <= dump_nx;
      bank_q               <= bank_nx;
      busy                 <= busy_nx;
      done                 <= done_nx;
      cmd.random_run       <= rr_nx;
      cmd.distance_com     <= dcom_nx;
      cmd.metropolis_run   <= metro_nx;
      cmd.replica_run      <= repl_nx;
      cmd.exchange_run     <= exch_nx;
      cmd.exchange_valid   <= ev_nx;
      cmd.distance_shift   <= dshift_nx;
      cmd.exchange_shift_d <= eshift_nx;
    end
  end

  // Next state and next output values; outputs decode from the next state so they register with it
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    stop_nx     = stop_q;
    iter_num_nx = iter_num_q;
    iter_cnt_nx = iter_cnt_q;
    mode_nx     = mode_q;
    opt_nx      = opt_q;
    dump_nx     = dump_q;
    bank_nx     = bank_q;
    run_st      = (state >= S_RAND) && (state <= S_EWAIT);

    case (state)
      S_IDLE: begin
        if (start) begin
          iter_cnt_nx = '0;
          stop_nx     = 1'b0;
          iter_num_nx = iter_num;
          dump_nx     = dump_en;
          mode_nx     = opt_mode;
          opt_nx      = (opt_mode == 2'd1) ? 2'd1 : 2'd0;
          phase_nx    = '0;
          state_nx    = (iter_num == 32'd0) ? S_FIN : S_RAND;
        end
      end
      S_RAND: begin
        state_nx = S_DIST;
        phase_nx = '0;
      end
      S_DIST: begin
        if (phase == DIST_LAST) begin
          state_nx = S_METRO;
          phase_nx = '0;
        end else begin
          phase_nx = phase + CNT_W'(1);
        end
      end
      S_METRO: state_nx = S_REPL;
      S_REPL:  state_nx = S_EXCH;
      S_EXCH: begin
        state_nx = S_EWAIT;
        phase_nx = '0;
      end
      S_EWAIT: begin
        if (phase == EXCH_LAST) begin
          iter_cnt_nx = iter_cnt_q + 32'd1;
          bank_nx     = ~bank_q;
          phase_nx    = '0;
          if (mode_q == 2'd2) opt_nx = {1'b0, ~opt_q[0]};
          // A stop arriving on the very last cycle still ends the run here
          if ((iter_cnt_nx < iter_num_q) && !(stop_q || stop)) state_nx = S_RAND;
          else if (dump_q)                                     state_nx = S_DUMPD;
          else                                                 state_nx = S_FIN;
        end else begin
          phase_nx = phase + CNT_W'(1);
        end
      end
      S_DUMPD: begin
        if (phase == REPL_LAST) begin
          state_nx = S_DUMPO;
          phase_nx = '0;
        end else begin
          phase_nx = phase + CNT_W'(1);
        end
      end
      S_DUMPO: begin
        if (phase == CITY_LAST) begin
          state_nx = S_FIN;
          phase_nx = '0;
        end else begin
          phase_nx = phase + CNT_W'(1);
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (run_st && stop) stop_nx = 1'b1;

    busy_nx   = (state_nx != S_IDLE) && (state_nx != S_FIN);
    done_nx   = (state_nx == S_FIN);
    rr_nx     = (state_nx == S_RAND);
    metro_nx  = (state_nx == S_METRO);
    repl_nx   = (state_nx == S_REPL);
    exch_nx   = (state_nx == S_EXCH);
    ev_nx     = (state_nx >= S_DIST) && (state_nx <= S_EWAIT);
    dshift_nx = (state_nx == S_DUMPD);
    eshift_nx = (state_nx == S_DUMPO);
    dcom_nx   = 3'b000;
    if (state_nx == S_DIST) begin
      if (phase_nx == '0)             dcom_nx = 3'b001;
      else if (phase_nx == DIST_LAST) dcom_nx = 3'b100;
      else                            dcom_nx = 3'b010;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_q;

  // Busy-cycle counter, cleared on accepted start and frozen once idle
  always_ff @(posedge clk) begin
    if (!reset)                      cycle_q <= '0;
    else if (state == S_IDLE && start) cycle_q <= '0;
    else if (busy)                   cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_anneal_sequencer.sv
// Directed bench for anneal_sequencer: a run-level schedule model fills an expectation queue
// that one negedge process compares against the DUT every cycle, plus literal spot checks.
module tb_anneal_sequencer;

  localparam int REPLICA_NUM = 32;
  localparam int CITY_NUM    = 64;
  localparam int DIST_CYC    = 4;
  localparam int EXCH_CYC    = 8;
  localparam int ITER_LEN    = DIST_CYC + EXCH_CYC + 4;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [31:0] iter_cnt;
    logic [1:0]  opt;
    logic        rr;
    logic [2:0]  dcom;
    logic        metro;
    logic        repl;
    logic        exch;
    logic        ev;
    logic        bank;
    logic        ds;
    logic        es;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] iter_num;
  logic [1:0]  opt_mode;
  logic        dump_en;
  logic        busy;
  logic        done;
  logic [31:0] iter_cnt;
  logic [31:0] cycle_count;

  anneal_sequencer_if cmd ();

  anneal_sequencer #(
    .REPLICA_NUM (REPLICA_NUM),
    .CITY_NUM    (CITY_NUM),
    .DIST_CYC    (DIST_CYC),
    .EXCH_CYC    (EXCH_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .iter_num    (iter_num),
    .opt_mode    (opt_mode),
    .dump_en     (dump_en),
    .busy        (busy),
    .done        (done),
    .iter_cnt    (iter_cnt),
    .cycle_count (cycle_count),
    .cmd         (cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e;

  // model state that persists between runs
  logic [31:0] m_iter_cnt = '0;
  logic [1:0]  m_opt      = '0;
  logic        m_bank     = 1'b0;

  int         rr_n = 0;
  int         ds_n = 0;
  int         es_n = 0;
  logic [1:0] rr_opt [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r          = '0;
    r.iter_cnt = m_iter_cnt;
    r.opt      = m_opt;
    r.bank     = m_bank;
    return r;
  endfunction

  // Expected per-cycle outputs of one run, record 0 being the cycle start is driven in
  task automatic model_run(input int n, input logic [1:0] mode, input bit dump,
                           input int stop_it, input int max_rec);
    exp_t r;
    exp_t recs[$];
    int   runs;
    recs.push_back(idle_rec());
    m_iter_cnt = '0;
    m_opt      = (mode == 2'd1) ? 2'd1 : 2'd0;
    runs       = (stop_it != 0 && stop_it < n) ? stop_it : n;
    for (int it = 0; it < runs; it++) begin
      for (int c = 0; c < ITER_LEN; c++) begin
        r = idle_rec();
        r.busy  = 1'b1;
        r.rr    = (c == 0);
        r.ev    = (c != 0);
        if (c == 1)                        r.dcom = 3'b001;
        else if (c == DIST_CYC)            r.dcom = 3'b100;
        else if (c > 1 && c < DIST_CYC)    r.dcom = 3'b010;
        r.metro = (c == DIST_CYC + 1);
        r.repl  = (c == DIST_CYC + 2);
        r.exch  = (c == DIST_CYC + 3);
        recs.push_back(r);
      end
      m_iter_cnt = m_iter_cnt + 32'd1;
      m_bank     = ~m_bank;
      if (mode == 2'd2) m_opt = m_opt ^ 2'd1;
    end
    if (dump && n != 0) begin
      for (int i = 0; i < REPLICA_NUM + CITY_NUM; i++) begin
        r      = idle_rec();
        r.busy = 1'b1;
        r.ds   = (i < REPLICA_NUM);
        r.es   = (i >= REPLICA_NUM);
        recs.push_back(r);
      end
    end
    r      = idle_rec();
    r.done = 1'b1;
    recs.push_back(r);
    for (int i = 0; i < recs.size() && i < max_rec; i++) exp_q.push_back(recs[i]);
  endtask

  // Single compare process plus pulse monitors
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy",             32'(busy),                 32'(e.busy));
      chk("done",             32'(done),                 32'(e.done));
      chk("iter_cnt",         iter_cnt,                  e.iter_cnt);
      chk("cycle_count",      cycle_count,               32'd0);
      chk("opt_command",      32'(cmd.opt_command),      32'(e.opt));
      chk("random_run",       32'(cmd.random_run),       32'(e.rr));
      chk("distance_com",     32'(cmd.distance_com),     32'(e.dcom));
      chk("metropolis_run",   32'(cmd.metropolis_run),   32'(e.metro));
      chk("replica_run",      32'(cmd.replica_run),      32'(e.repl));
      chk("exchange_run",     32'(cmd.exchange_run),     32'(e.exch));
      chk("exchange_valid",   32'(cmd.exchange_valid),   32'(e.ev));
      chk("exchange_bank",    32'(cmd.exchange_bank),    32'(e.bank));
      chk("distance_shift",   32'(cmd.distance_shift),   32'(e.ds));
      chk("exchange_shift_d", 32'(cmd.exchange_shift_d), 32'(e.es));
    end
    if (cmd.random_run) begin
      if (rr_n < 8) rr_opt[rr_n] = cmd.opt_command;
      rr_n++;
    end
    if (cmd.distance_shift)   ds_n++;
    if (cmd.exchange_shift_d) es_n++;
  end

  task automatic start_run(input int n, input logic [1:0] mode, input bit dump);
    iter_num = 32'(n);
    opt_mode = mode;
    dump_en  = dump;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout actual=no_done required=done t=%0t", $time);
    exp_q.delete();
  endtask

  task automatic run_test(input int n, input logic [1:0] mode, input bit dump, output int cyc);
    rr_n = 0;
    ds_n = 0;
    es_n = 0;
    model_run(n, mode, dump, 0, 100000);
    start_run(n, mode, dump);
    wait_done(cyc);
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      chk("queue_drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int cyc;
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    iter_num = '0;
    opt_mode = '0;
    dump_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    reset = 1'b1;

    // single iteration, fixed or-opt
    run_test(1, 2'd0, 1'b0, cyc);
    chk("t1_done_cycle", 32'(cyc), 32'd17);
    chk("t1_iter_cnt",   iter_cnt, 32'd1);
    chk("t1_bank",       32'(cmd.exchange_bank), 32'd1);
    chk("t1_rr_count",   32'(rr_n), 32'd1);

    // single iteration with dump phase
    run_test(1, 2'd0, 1'b1, cyc);
    chk("dump_done_cycle", 32'(cyc), 32'd113);
    chk("dump_ds_count",   32'(ds_n), 32'd32);
    chk("dump_es_count",   32'(es_n), 32'd64);

    // four iterations, alternating opt
    run_test(4, 2'd2, 1'b0, cyc);
    chk("alt_rr_count", 32'(rr_n), 32'd4);
    chk("alt_opt0", 32'(rr_opt[0]), 32'd0);
    chk("alt_opt1", 32'(rr_opt[1]), 32'd1);
    chk("alt_opt2", 32'(rr_opt[2]), 32'd0);
    chk("alt_opt3", 32'(rr_opt[3]), 32'd1);
    chk("alt_bank", 32'(cmd.exchange_bank), 32'd0);
    chk("alt_iter_cnt", iter_cnt, 32'd4);

    // stop pulsed during the DIST phase of iteration 3
    rr_n = 0;
    model_run(100, 2'd0, 1'b0, 3, 100000);
    start_run(100, 2'd0, 1'b0);
    repeat (2 * ITER_LEN + 1) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(cyc);
    chk("stop_iter_cnt", iter_cnt, 32'd3);
    @(posedge clk); #1;
    chk("stop_rr_count", 32'(rr_n), 32'd3);
    exp_q.delete();

    // zero iterations
    run_test(0, 2'd0, 1'b0, cyc);
    chk("zero_done_cycle", 32'(cyc), 32'd1);
    chk("zero_rr_count",   32'(rr_n), 32'd0);
    chk("zero_iter_cnt",   iter_cnt, 32'd0);

    // fixed 2-opt, and mode 3 behaving as or-opt
    run_test(2, 2'd1, 1'b0, cyc);
    chk("m1_opt", 32'(rr_opt[1]), 32'd1);
    run_test(2, 2'd3, 1'b0, cyc);
    chk("m3_opt", 32'(rr_opt[1]), 32'd0);

    // reset in the EWAIT phase of iteration 2
    model_run(100, 2'd0, 1'b0, 0, ITER_LEN + 13);
    start_run(100, 2'd0, 1'b0);
    repeat (ITER_LEN + 11) @(posedge clk);
    #1 reset = 1'b0;
    m_iter_cnt = '0;
    m_opt      = '0;
    m_bank     = 1'b0;
    exp_q.push_back('0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back('0);
    repeat (3) @(posedge clk);
    #1;
    run_test(1, 2'd0, 1'b0, cyc);
    chk("post_rst_done_cycle", 32'(cyc), 32'd17);
    chk("post_rst_bank",       32'(cmd.exchange_bank), 32'd1);
    chk("post_rst_iter_cnt",   iter_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
